// File: rtl/vga_bar_renderer.sv
// N-bar renderer: double-buffered bar heights and highlights, 2-cycle pixel pipeline to registered RGB/sync.
// Optional VGA_BAR_BORDER_EN macro draws a 1-px black ring around each drawn bar.
module vga_bar_renderer #(
  parameter int              NUM_BARS  = 8,
  parameter int              IDX_W     = 4,
  parameter int              HGT_W     = 10,
  parameter int              BAR_W     = 64,
  parameter int              BAR_GAP   = 32,
  parameter int              BASE_Y    = 570,
  parameter logic [11:0]     BG_COLOR  = 12'hAAA,
  parameter logic [11:0]     BAR_COLOR = 12'hF00,
  parameter logic [11:0]     HLA_COLOR = 12'h0F0,
  parameter logic [11:0]     HLB_COLOR = 12'h00F
) (
  input  logic             i_pclk,
  input  logic             i_rst,
  input  logic [10:0]      i_hcount,
  input  logic [10:0]      i_vcount,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic             i_hblnk,
  input  logic             i_vblnk,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [HGT_W-1:0] i_wr_height,
  input  logic             i_hla_en,
  input  logic [IDX_W-1:0] i_hla_idx,
  input  logic             i_hlb_en,
  input  logic [IDX_W-1:0] i_hlb_idx,
  output logic             o_hs,
  output logic             o_vs,
  output logic [3:0]       o_r,
  output logic [3:0]       o_g,
  output logic [3:0]       o_b,
  output logic             o_frame_tick
);

  localparam logic [11:0]      L_BASE_Y = 12'(BASE_Y);
  localparam logic [IDX_W-1:0] L_NONE   = IDX_W'(NUM_BARS);

  logic [HGT_W-1:0] r_stg_h [NUM_BARS];
  logic [HGT_W-1:0] r_act_h [NUM_BARS];
  logic             r_stg_hla_en, r_stg_hlb_en, r_act_hla_en, r_act_hlb_en;
  logic [IDX_W-1:0] r_stg_hla_idx, r_stg_hlb_idx, r_act_hla_idx, r_act_hlb_idx;
  logic             r_vblnk_q;
  logic             w_commit;

  assign w_commit = i_vblnk && !r_vblnk_q;

  // Staging is written freely; the active bank only changes on a vblnk rise,
  // and reads the pre-edge staging value so a same-cycle write lands next frame.
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_BARS; i++) begin
        r_stg_h[i] <= '0;
        r_act_h[i] <= '0;
      end
      r_stg_hla_en  <= 1'b0;
      r_stg_hlb_en  <= 1'b0;
      r_stg_hla_idx <= '0;
      r_stg_hlb_idx <= '0;
      r_act_hla_en  <= 1'b0;
      r_act_hlb_en  <= 1'b0;
      r_act_hla_idx <= '0;
      r_act_hlb_idx <= '0;
      r_vblnk_q     <= 1'b0;
      o_frame_tick  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BARS; i++) begin
        if (i_wr_en && (i_wr_idx == IDX_W'(i))) r_stg_h[i] <= i_wr_height;
        if (w_commit) r_act_h[i] <= r_stg_h[i];
      end
      r_stg_hla_en  <= i_hla_en;
      r_stg_hlb_en  <= i_hlb_en;
      r_stg_hla_idx <= i_hla_idx;
      r_stg_hlb_idx <= i_hlb_idx;
      if (w_commit) begin
        r_act_hla_en  <= r_stg_hla_en;
        r_act_hlb_en  <= r_stg_hlb_en;
        r_act_hla_idx <= r_stg_hla_idx;
        r_act_hlb_idx <= r_stg_hlb_idx;
      end
      r_vblnk_q    <= i_vblnk;
      o_frame_tick <= w_commit;
    end
  end

  logic [11:0]         w_x, w_y;
  logic [NUM_BARS-1:0] w_in;
  logic [NUM_BARS-1:0] w_ring;

  assign w_x = {1'b0, i_hcount};
  assign w_y = {1'b0, i_vcount};

  for (genvar gi = 0; gi < NUM_BARS; gi++) begin : g_bar
    localparam logic [11:0] L_X0 = 12'(BAR_GAP + gi * (BAR_W + BAR_GAP));
    localparam logic [11:0] L_X1 = 12'(BAR_GAP + gi * (BAR_W + BAR_GAP) + BAR_W - 1);
    logic [11:0] w_h12, w_heff, w_ytop;
    assign w_h12    = 12'(r_act_h[gi]);
    assign w_heff   = (w_h12 > L_BASE_Y) ? L_BASE_Y : w_h12;
    assign w_ytop   = L_BASE_Y - w_heff;
    assign w_in[gi] = (w_heff != 12'd0) && (w_x >= L_X0) && (w_x <= L_X1) &&
                      (w_y >= w_ytop) && (w_y < L_BASE_Y);
`ifdef VGA_BAR_BORDER_EN
    assign w_ring[gi] = (w_x == L_X0) || (w_x == L_X1) ||
                        (w_y == w_ytop) || (w_y == L_BASE_Y - 12'd1);
`else
    assign w_ring[gi] = 1'b0;
`endif
  end

  logic [IDX_W-1:0] w_hit;
  logic             w_hit_ring;

  // Walk downward so the lowest-numbered overlapping bar wins.
  always_comb begin
    w_hit      = L_NONE;
    w_hit_ring = 1'b0;
    for (int i = NUM_BARS - 1; i >= 0; i--) begin
      if (w_in[i]) begin
        w_hit      = IDX_W'(i);
        w_hit_ring = w_ring[i];
      end
    end
  end

  logic [IDX_W-1:0] r_s1_hit;
  logic             r_s1_ring, r_s1_hs, r_s1_vs, r_s1_blank;

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_s1_hit   <= L_NONE;
      r_s1_ring  <= 1'b0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_s1_blank <= 1'b1;
    end else begin
      r_s1_hit   <= w_hit;
      r_s1_ring  <= w_hit_ring;
      r_s1_hs    <= i_hsync;
      r_s1_vs    <= i_vsync;
      r_s1_blank <= i_hblnk || i_vblnk;
    end
  end

  logic        w_is_bar, w_hla_hit, w_hlb_hit;
  logic [11:0] w_color;

  assign w_is_bar  = r_s1_hit < L_NONE;
  assign w_hla_hit = r_act_hla_en && (r_act_hla_idx < L_NONE) && (r_s1_hit == r_act_hla_idx);
  assign w_hlb_hit = r_act_hlb_en && (r_act_hlb_idx < L_NONE) && (r_s1_hit == r_act_hlb_idx);

  always_comb begin
    w_color = BG_COLOR;
    if (r_s1_blank)                  w_color = 12'h000;
    else if (w_is_bar && r_s1_ring)  w_color = 12'h000;
    else if (w_hla_hit)              w_color = HLA_COLOR;
    else if (w_hlb_hit)              w_color = HLB_COLOR;
    else if (w_is_bar)               w_color = BAR_COLOR;
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      o_hs              <= 1'b0;
      o_vs              <= 1'b0;
      {o_r, o_g, o_b}   <= 12'h000;
    end else begin
      o_hs              <= r_s1_hs;
      o_vs              <= r_s1_vs;
      {o_r, o_g, o_b}   <= w_color;
    end
  end

endmodule

// File: tb/tb_vga_bar_renderer.sv
// Directed bench for vga_bar_renderer (default parameters, border disabled).
module tb_vga_bar_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hc, vc;
  logic        hs_in, vs_in, hb, vb;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [9:0]  wr_h;
  logic        hla_en, hlb_en;
  logic [3:0]  hla_idx, hlb_idx;
  logic        hs_o, vs_o, tick;
  logic [3:0]  r, g, b;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  vga_bar_renderer dut (
    .i_pclk(clk), .i_rst(rst), .i_hcount(hc), .i_vcount(vc),
    .i_hsync(hs_in), .i_vsync(vs_in), .i_hblnk(hb), .i_vblnk(vb),
    .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_height(wr_h),
    .i_hla_en(hla_en), .i_hla_idx(hla_idx), .i_hlb_en(hlb_en), .i_hlb_idx(hlb_idx),
    .o_hs(hs_o), .o_vs(vs_o), .o_r(r), .o_g(g), .o_b(b), .o_frame_tick(tick)
  );

  typedef struct {
    string       name;
    logic [10:0] x;
    logic [10:0] y;
    logic [11:0] rgb;
  } vec_t;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic pix(input string nm, input logic [10:0] x, input logic [10:0] y,
                     input logic [11:0] exp);
    @(posedge clk); #1;
    hc = x; vc = y; hb = 1'b0; vb = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk(nm, {r, g, b}, exp);
  endtask

  task automatic wr(input logic [3:0] idx, input logic [9:0] h);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_idx = idx; wr_h = h;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic commit(input string nm);
    @(posedge clk); #1;
    vb = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_tick"}, {11'd0, tick}, 12'd1);
    vb = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_tick_end"}, {11'd0, tick}, 12'd0);
  endtask

  vec_t t1 [6];
  logic [11:0] hs_pat;

  initial begin
    t1[0] = '{"t1_in",      11'd32, 11'd300, 12'hF00};
    t1[1] = '{"t1_above",   11'd32, 11'd299, 12'hAAA};
    t1[2] = '{"t1_right",   11'd96, 11'd300, 12'hAAA};
    t1[3] = '{"t1_left",    11'd31, 11'd569, 12'hAAA};
    t1[4] = '{"t1_corner",  11'd95, 11'd569, 12'hF00};
    t1[5] = '{"t1_base",    11'd32, 11'd570, 12'hAAA};

    rst = 1'b1; hc = '0; vc = '0; hs_in = 1'b1; vs_in = 1'b1; hb = 1'b0; vb = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_h = '0;
    hla_en = 1'b0; hla_idx = '0; hlb_en = 1'b0; hlb_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {r, g, b}, 12'h000);
    chk("rst_hs", {11'd0, hs_o}, 12'd0);
    chk("rst_vs", {11'd0, vs_o}, 12'd0);
    chk("rst_tick", {11'd0, tick}, 12'd0);
    rst = 1'b0; hs_in = 1'b0; vs_in = 1'b0;

    // 1: single bar geometry
    wr(4'd0, 10'd270);
    pix("t1_precommit", 11'd32, 11'd300, 12'hAAA);
    commit("t1");
    for (int i = 0; i < 6; i++) pix(t1[i].name, t1[i].x, t1[i].y, t1[i].rgb);

    // 2: mid-frame write stays hidden until the next commit
    @(posedge clk); #1; vc = 11'd200;
    wr(4'd1, 10'd100);
    pix("t2_same_frame", 11'd128, 11'd500, 12'hAAA);
    pix("t2_same_frame2", 11'd191, 11'd569, 12'hAAA);
    commit("t2");
    pix("t2_next_frame", 11'd128, 11'd500, 12'hF00);
    pix("t2_top_edge", 11'd150, 11'd470, 12'hF00);
    pix("t2_above", 11'd150, 11'd469, 12'hAAA);

    // 2b: write in the commit cycle lands one frame later
    @(posedge clk); #1;
    vb = 1'b1; wr_en = 1'b1; wr_idx = 4'd3; wr_h = 10'd10;
    @(posedge clk); #1;
    vb = 1'b0; wr_en = 1'b0;
    chk("t2b_tick", {11'd0, tick}, 12'd1);
    pix("t2b_old", 11'd320, 11'd565, 12'hAAA);
    commit("t2b");
    pix("t2b_new", 11'd320, 11'd565, 12'hF00);

    // 3: highlights
    hla_en = 1'b1; hla_idx = 4'd1; hlb_en = 1'b1; hlb_idx = 4'd1;
    pix("t3_staged_only", 11'd150, 11'd520, 12'hF00);
    commit("t3a");
    pix("t3_a_wins", 11'd150, 11'd520, 12'h0F0);
    pix("t3_bar0_plain", 11'd40, 11'd520, 12'hF00);
    hla_en = 1'b0;
    commit("t3b");
    pix("t3_b_only", 11'd150, 11'd520, 12'h00F);
    hlb_en = 1'b0;
    commit("t3c");
    pix("t3_none", 11'd150, 11'd520, 12'hF00);

    // 4: out-of-range index writes and highlights
    wr(4'd8, 10'd300);
    commit("t4a");
    pix("t4_bar0", 11'd32, 11'd299, 12'hAAA);
    pix("t4_bar7_empty", 11'd704, 11'd569, 12'hAAA);
    hla_en = 1'b1; hla_idx = 4'd9; hlb_en = 1'b1; hlb_idx = 4'd8;
    commit("t4b");
    pix("t4_hl9", 11'd32, 11'd300, 12'hF00);
    pix("t4_hl8_bg", 11'd0, 11'd0, 12'hAAA);
    hla_en = 1'b0; hlb_en = 1'b0;
    wr(4'd7, 10'd50);
    commit("t4c");
    pix("t4_bar7_l", 11'd704, 11'd569, 12'hF00);
    pix("t4_bar7_r", 11'd767, 11'd520, 12'hF00);
    pix("t4_bar7_out", 11'd768, 11'd569, 12'hAAA);
    pix("t4_bar7_top", 11'd704, 11'd519, 12'hAAA);

    // 5: clamp, blanking, sync delay
    wr(4'd2, 10'd1023);
    commit("t5");
    pix("t5_clamp_top", 11'd224, 11'd0, 12'hF00);
    pix("t5_clamp_bot", 11'd287, 11'd569, 12'hF00);
    @(posedge clk); #1; hc = 11'd224; vc = 11'd0; hb = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("t5_hblnk", {r, g, b}, 12'h000);
    hb = 1'b0;
    hs_pat = 12'b1011_0011_0100;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k >= 2) begin
        chk("t5_hs_delay", {11'd0, hs_o}, {11'd0, hs_pat[k-2]});
        chk("t5_vs_delay", {11'd0, vs_o}, {11'd0, ~hs_pat[k-2]});
      end
      hs_in = hs_pat[k];
      vs_in = ~hs_pat[k];
    end
    hs_in = 1'b1; vs_in = 1'b0;

    // 6: reset mid-line
    pix("t6_before", 11'd32, 11'd300, 12'hF00);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_rgb", {r, g, b}, 12'h000);
    chk("t6_rst_hs", {11'd0, hs_o}, 12'd0);
    rst = 1'b0;
    pix("t6_after_bar0", 11'd32, 11'd300, 12'hAAA);
    pix("t6_after_bar2", 11'd224, 11'd0, 12'hAAA);
    commit("t6");
    pix("t6_zero_commit", 11'd224, 11'd10, 12'hAAA);
    wr(4'd0, 10'd5);
    commit("t6b");
    pix("t6_new_bar", 11'd50, 11'd566, 12'hF00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
